data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, cycles from request accept to response valid (legal 1..7).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  1  CPU memory stage presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  32  byte address.
REQ-009 Port req_wdata  input  32  store data.
REQ-010 Port req_be  input  4  byte enables for stores; bit i selects wdata[8i+7:8i]; ignored on loads.
REQ-011 Port resp_valid  output  1  response available.
REQ-012 Port resp_ready  input  1  CPU accepts response this cycle.
REQ-013 Port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 Port resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 Request accepted on a cycle with req_valid and req_ready both 1; at most one transaction outstanding.
REQ-016 States: IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; on accept capture write/addr/wdata/be, load counter with LATENCY-1, go WAIT (LATENCY=1: go straight to RESP on next edge with commit as REQ-019).
REQ-018 WAIT: req_ready=0; counter decrements each cycle; when counter is 0 go RESP and commit.
REQ-019 Commit: load reads word addr[31:2] into resp_rdata; store writes enabled bytes; occurs on the edge entering RESP.
REQ-020 RESP: resp_valid=1, req_ready=0; resp_rdata/resp_err held stable until resp_ready=1; then go IDLE.
REQ-021 Consequence: resp_valid rises exactly LATENCY cycles after accept edge; no new request accepted in the same cycle as response handshake (next accept earliest one cycle after).
REQ-022 Error: addr[1:0]!=0 or addr[31:2] >= DEPTH_WORDS -> resp_err=1, resp_rdata=0, no memory write; timing identical to normal request.
REQ-023 Store with req_be=0 is legal: no bytes change, resp_err=0.
REQ-024 Captured request fields are immune to input changes after accept.
REQ-025 Load after store to same word observes stored data (no stale read).

Reset
REQ-026 reset=1 forces IDLE; req_ready=1 the cycle after reset deasserts... while reset held: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-027 Reset during WAIT aborts transaction; no store committed. Reset during RESP discards response.
REQ-028 Memory array contents are not cleared by reset.

Structure
REQ-029 Shared package data_mem_pkg holds state enum, LATENCY_MIN=1, LATENCY_MAX=7, counter width (3 bits).
REQ-030 One sub-module data_mem_array: synchronous word RAM with per-byte write enables, one read/write port.
REQ-031 Controller FSM, counter and error decode live in data_mem_responder; elaboration fails for LATENCY outside 1..7.

Verification
REQ-032 LATENCY=2: store addr 0x10 data 0xDEADBEEF be=1111, then load 0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 Byte enables: store 0x11223344 be=1111 to 0x20, store 0xAABBCCDD be=0101 -> load 0x20 returns 0x11BB33DD.
REQ-034 Backpressure: load accepted, resp_ready held 0 for 5 cycles -> resp_valid and rdata stable 5 cycles, req_ready 0 throughout, accept only after handshake.
REQ-035 Errors: load 0x13 -> err 1, rdata 0; store 0x00001000 with DEPTH_WORDS=1024 -> err 1, later load 0x0 unchanged.
REQ-036 Reset mid-WAIT: LATENCY=4, store 0xCAFEF00D to 0x8, reset at cycle 2 -> no response, load 0x8 returns prior value.
REQ-037 LATENCY=1 back-to-back loads with resp_ready tied 1 -> one accept every 2 cycles, correct data each.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM states, latency limits and counter width for the data memory responder
package data_mem_pkg;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word RAM with byte write enables; ports clk, en, we[3:0], addr, wdata in, rdata out (registered, read-before-write)
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;
  always_comb rdata_d = en ? mem[addr] : rdata_q;
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int i = 0; i < 4; i++)
      if (en && we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency valid/ready data memory; ports clk, reset, req_* (valid/ready/write/addr/wdata/be), resp_* (valid/ready/rdata/err)
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 1..7");
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
    $error("data_mem_responder: DEPTH_WORDS must be a power of two in 16..65536");
  end
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic commit, req_err;
  logic [31:0] ram_rdata;
  assign req_err = (|req_addr[1:0]) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
  // The _d request fields feed the RAM so a LATENCY=1 commit on the accept edge sees the live request.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    err_d = err_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    commit = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d = req_write;
        err_d = req_err;
        waddr_d = req_addr[AW+1:2];
        wdata_d = req_wdata;
        be_d = req_be;
        cnt_d = CNT_W'(LATENCY - 1);
        commit = LATENCY == 1;
        state_d = LATENCY == 1 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        commit = cnt_q == CNT_W'(1);
        state_d = commit ? RESP : WAIT;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      err_q <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
    end
  end
  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (commit && !reset),
    .we    ((wr_d && !err_d) ? be_d : 4'b0),
    .addr  (waddr_d),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );
  assign req_ready = state_q == IDLE && !reset;
  assign resp_valid = state_q == RESP;
  assign resp_err = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !wr_q && !err_q) ? ram_rdata : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector bench over three responders with LATENCY 2, 4 and 1
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset [3];
  logic req_valid [3];
  logic req_write [3];
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [3:0] req_be [3];
  logic resp_ready [3];
  logic req_ready [3];
  logic resp_valid [3];
  logic resp_err [3];
  logic [31:0] resp_rdata [3];
  int lat_of [3] = '{2, 4, 1};
  int nvec = 0;
  int nfail = 0;
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));
  typedef struct {
    int d;
    bit wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] rd;
    bit err;
    int stall;
  } vec_t;
  vec_t tv [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Entered just after a posedge with the DUT idle; leaves just after the handshake edge.
  task automatic xact(input vec_t v);
    int lat;
    req_valid[v.d] = 1'b1;
    req_write[v.d] = v.wr;
    req_addr[v.d] = v.addr;
    req_wdata[v.d] = v.wdata;
    req_be[v.d] = v.be;
    resp_ready[v.d] = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_idle@%h", v.addr), 32'(req_ready[v.d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[v.d] = 1'b0;
    req_write[v.d] = 1'($urandom);
    req_addr[v.d] = $urandom;
    req_wdata[v.d] = $urandom;
    req_be[v.d] = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid[v.d] && req_ready[v.d]) chk("ready_wait", 32'(req_ready[v.d]), 32'd0);
    end while (!resp_valid[v.d] && lat < 16);
    chk($sformatf("latency@%h", v.addr), 32'(lat), 32'(lat_of[v.d]));
    chk($sformatf("rdata@%h", v.addr), resp_rdata[v.d], v.rd);
    chk($sformatf("err@%h", v.addr), 32'(resp_err[v.d]), 32'(v.err));
    chk("ready_resp", 32'(req_ready[v.d]), 32'd0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", s), 32'(resp_valid[v.d]), 32'd1);
      chk($sformatf("stall%0d_rdata", s), resp_rdata[v.d], v.rd);
      chk($sformatf("stall%0d_ready", s), 32'(req_ready[v.d]), 32'd0);
    end
    resp_ready[v.d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[v.d] = 1'b0;
  endtask
  logic [31:0] b2b_vals [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i] = '0;
      req_wdata[i] = '0;
      req_be[i] = '0;
      resp_ready[i] = 1'b0;
    end
    tv.push_back('{0, 1'b1, 32'h0000_0000, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0013, 32'h0, 4'h0, 32'h0, 1'b1, 0});
    tv.push_back('{0, 1'b1, 32'h0000_1000, 32'h12345678, 4'hF, 32'h0, 1'b1, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0022, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0FFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0024, 32'h01020304, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b1, 32'h0000_0024, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h01020304, 1'b0, 0});
    tv.push_back('{0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5});
    tv.push_back('{0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 0});
    tv.push_back('{1, 1'b1, 32'h0000_0008, 32'h13572468, 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h13572468, 1'b0, 0});
    for (int i = 0; i < 4; i++)
      tv.push_back('{2, 1'b1, 32'h40 + 32'(4*i), b2b_vals[i], 4'hF, 32'h0, 1'b0, 0});
    tv.push_back('{2, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h22222222, 1'b0, 0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), resp_rdata[i], 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(resp_err[i]), 32'd0);
      reset[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    foreach (tv[i]) xact(tv[i]);
    // Reset two cycles into a LATENCY=4 store: the store must never land.
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1] = 32'h8;
    req_wdata[1] = 32'hCAFEF00D;
    req_be[1] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    reset[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready[1]), 32'd0);
    chk("midrst_valid", 32'(resp_valid[1]), 32'd0);
    chk("midrst_rdata", resp_rdata[1], 32'd0);
    chk("midrst_err", 32'(resp_err[1]), 32'd0);
    reset[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_valid", k), 32'(resp_valid[1]), 32'd0);
      chk($sformatf("postrst%0d_ready", k), 32'(req_ready[1]), 32'd1);
    end
    @(posedge clk);
    #1;
    xact('{1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h13572468, 1'b0, 0});
    // LATENCY=1 back-to-back loads with resp_ready tied high: accept on even cycles, data on odd.
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_addr[2] = 32'h40;
    resp_ready[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_ready", k), 32'(req_ready[2]), 32'(k % 2 == 0));
      chk($sformatf("b2b%0d_valid", k), 32'(resp_valid[2]), 32'(k % 2 == 1));
      if (k % 2 == 1) begin
        chk($sformatf("b2b%0d_rdata", k), resp_rdata[2], b2b_vals[(k-1)/2]);
        req_addr[2] = 32'h40 + 32'(4*((k+1)/2));
      end
      if (k == 7) req_valid[2] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_done_valid", 32'(resp_valid[2]), 32'd0);
    resp_ready[2] = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
